// File: rtl/gas_pkg.sv
// Shared types and helpers for the multi-channel gas detector.
package gas_pkg;

  typedef enum logic [1:0] {
    SAFE  = 2'd0,
    WARN  = 2'd1,
    ALARM = 2'd2
  } gas_state_e;

  localparam logic [2:0] ST_SAFE  = 3'b001;
  localparam logic [2:0] ST_WARN  = 3'b010;
  localparam logic [2:0] ST_ALARM = 3'b100;

  // Bits needed to hold a density from 0 up to and including win.
  function automatic int cnt_width(input int win);
    return $clog2(win + 1);
  endfunction

  // Channel-select width, never narrower than one bit.
  function automatic int sel_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/gas_detector_array_if.sv
// Sensor-side / controller-side signal bundle of gas_detector_array.
// master drives samples, acknowledge and channel select; slave is the detector.
interface gas_detector_array_if
  import gas_pkg::*;
#(
  parameter int CH  = 4,
  parameter int WIN = 12
);
  localparam int SW = sel_width(CH);
  localparam int CW = cnt_width(WIN);

  logic [CH-1:0]  din;
  logic           ack;
  logic [SW-1:0]  ch_sel;
  logic [2:0]     dout;
  logic [WIN-1:0] seq;
  logic [CW-1:0]  peak_cnt;
  logic [CH-1:0]  hot_mask;

  modport master (
    output din, ack, ch_sel,
    input  dout, seq, peak_cnt, hot_mask
  );

  modport slave (
    input  din, ack, ch_sel,
    output dout, seq, peak_cnt, hot_mask
  );

endinterface

// File: rtl/gas_window_counter.sv
// One sensor channel: WIN-sample sliding window and its popcount (density).
module gas_window_counter
  import gas_pkg::*;
#(
  parameter  int WIN = 12,
  localparam int CW  = cnt_width(WIN)
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           din,
  output logic [WIN-1:0] window,
  output logic [CW-1:0]  cnt
);

  // Shift the newest sample into bit 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) window <= '0;
    else      window <= {window[WIN-2:0], din};
  end

  // Count ones currently in the window.
  // NOTE: default every always_comb output first so no path leaves it
  // unassigned and a latch cannot be inferred.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIN; i++) cnt = cnt + CW'(window[i]);
  end

endmodule

// File: rtl/gas_detector_array.sv
// Multi-channel gas detector: per-channel density windows feeding a shared
// SAFE/WARN/ALARM state machine with hold-off and one-count hysteresis.
// Optional build macro GAS_ALARM_LATCH_EN makes ALARM sticky until an
// acknowledge arrives with every channel below the warn threshold.
module gas_detector_array
  import gas_pkg::*;
#(
  parameter int CH         = 4,
  parameter int WIN        = 12,
  parameter int WARN_TH    = 4,
  parameter int ALARM_TH   = 8,
  parameter int ALARM_HOLD = 3
) (
  input logic                 clk,
  input logic                 arst,
  gas_detector_array_if.slave bus
);

  localparam int CW = cnt_width(WIN);
  localparam int HW = $clog2(ALARM_HOLD + 1);

  localparam logic [CW-1:0] WARN_C  = CW'(WARN_TH);
  localparam logic [CW-1:0] HYS_C   = CW'(WARN_TH - 1);
  localparam logic [CW-1:0] ALARM_C = CW'(ALARM_TH);
  localparam logic [HW-1:0] HOLD_C  = HW'(ALARM_HOLD);

  logic [WIN-1:0] win_q [CH];
  logic [CW-1:0]  cnt   [CH];

  logic [CH-1:0]  hot_vec;
  logic           hot;
  logic           warm;
  logic           near;
  logic [CW-1:0]  peak_c;
  logic [WIN-1:0] seq_c;

  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_nxt;
  logic           alarm_go;

  gas_state_e     state;
  logic [2:0]     dout_q;
  logic [CW-1:0]  peak_q;
  logic [CH-1:0]  hot_mask_q;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    gas_window_counter #(.WIN(WIN)) u_win (
      .clk    (clk),
      .arst   (arst),
      .din    (bus.din[g]),
      .window (win_q[g]),
      .cnt    (cnt[g])
    );
  end

  // Threshold comparators and max-density reduction across channels.
  always_comb begin
    hot_vec = '0;
    warm    = 1'b0;
    near    = 1'b0;
    peak_c  = '0;
    for (int i = 0; i < CH; i++) begin
      if (cnt[i] >= ALARM_C) hot_vec[i] = 1'b1;
      if (cnt[i] >= WARN_C)  warm       = 1'b1;
      if (cnt[i] >= HYS_C)   near       = 1'b1;
      if (cnt[i] > peak_c)   peak_c     = cnt[i];
    end
  end

  assign hot = |hot_vec;

  // Window monitor mux; out-of-range selects read as all zeros.
  always_comb begin
    seq_c = '0;
    if (int'(bus.ch_sel) < CH) seq_c = win_q[bus.ch_sel];
  end

  // Next hold count: saturating run length of consecutive hot cycles.
  always_comb begin
    hold_nxt = '0;
    if (hot) hold_nxt = (hold_cnt == HOLD_C) ? hold_cnt : hold_cnt + 1'b1;
  end

  assign alarm_go = hot && (hold_nxt == HOLD_C);

  // Registered status outputs and hold counter.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hold_cnt   <= '0;
      peak_q     <= '0;
      hot_mask_q <= '0;
    end else begin
      hold_cnt   <= hold_nxt;
      peak_q     <= peak_c;
      hot_mask_q <= hot_vec;
    end
  end

  // SAFE/WARN/ALARM state machine with registered one-hot status.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state  <= SAFE;
      dout_q <= ST_SAFE;
    end else begin
      case (state)
        SAFE: begin
          if (warm) begin
            state  <= WARN;
            dout_q <= ST_WARN;
          end
        end
        WARN: begin
          if (alarm_go) begin
            state  <= ALARM;
            dout_q <= ST_ALARM;
          end else if (!near) begin
            state  <= SAFE;
            dout_q <= ST_SAFE;
          end
        end
        ALARM: begin
`ifdef GAS_ALARM_LATCH_EN
          if (bus.ack && !warm) begin
            state  <= SAFE;
            dout_q <= ST_SAFE;
          end
`else
          if (!warm) begin
            state  <= SAFE;
            dout_q <= ST_SAFE;
          end else if (!hot) begin
            state  <= WARN;
            dout_q <= ST_WARN;
          end
`endif
        end
        default: begin
          state  <= SAFE;
          dout_q <= ST_SAFE;
        end
      endcase
    end
  end

`ifndef GAS_ALARM_LATCH_EN
  // Acknowledge has no effect when ALARM is not latched.
  logic ack_unused;
  assign ack_unused = bus.ack;
`endif

  assign bus.dout     = dout_q;
  assign bus.peak_cnt = peak_q;
  assign bus.hot_mask = hot_mask_q;
  assign bus.seq      = seq_c;

endmodule
